// File: rtl/cp0_unit_p.sv
// ---------------------------------------------------------------------------
// cp0_unit_p - parametrised coprocessor-0 for the MIPS core (MEM/WB side)
//
// Owns Count/Compare/Status/Cause/EPC/PrId/Config.
// Features:
//   - Count prescaler
//   - two-flop synchroniser on the external interrupt lines
//   - registered, masked interrupt request for the ctrl stage
//   - read-after-write bypass on the read port
//   - exception redirect PC
//
// Optional build macro:
//   CP0_BADVADDR_EN - adds BadVAddr (reg 8) and the AdEL/AdES codes
//                     (0x04 / 0x05)
//
// Parameters:
//   INT_NUM    - number of external interrupt lines (1..6), Cause.IP[10+:INT_NUM]
//   COUNT_DIV  - Count advances once every COUNT_DIV cycles (1..16)
//   PRID_VAL   - constant PrId value
//   EXC_VECTOR - redirect target for every exception except ERET
//
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   we_i, waddr_i, data_i  CP0 register write (mtc0)
//   raddr_i, data_o        CP0 register read (combinational, bypassed)
//   excepttype_i           committed exception code, 0 = none
//   int_i                  asynchronous hardware interrupt lines
//   current_inst_addr_i    PC of the excepting instruction
//   is_in_delayslot_i      excepting instruction sits in a delay slot
//   bad_vaddr_i            faulting address (BadVAddr build only)
//   count_o .. prid_o      architectural register values
//   timer_int_o            sticky Count==Compare interrupt
//   int_req_o              interrupt request to the ctrl stage
//   exc_pc_o               redirect PC for excepttype_i
// ---------------------------------------------------------------------------
module cp0_unit_p #(
  parameter int unsigned INT_NUM    = 6,
  parameter int unsigned COUNT_DIV  = 1,
  parameter logic [31:0] PRID_VAL   = 32'h004C0102,
  parameter logic [31:0] EXC_VECTOR = 32'h00000020
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               we_i,
  input  logic [4:0]         waddr_i,
  input  logic [4:0]         raddr_i,
  input  logic [31:0]        data_i,
  input  logic [31:0]        excepttype_i,
  input  logic [INT_NUM-1:0] int_i,
  input  logic [31:0]        current_inst_addr_i,
  input  logic               is_in_delayslot_i,
  input  logic [31:0]        bad_vaddr_i,
  output logic [31:0]        data_o,
  output logic [31:0]        count_o,
  output logic [31:0]        compare_o,
  output logic [31:0]        status_o,
  output logic [31:0]        cause_o,
  output logic [31:0]        epc_o,
  output logic [31:0]        config_o,
  output logic [31:0]        prid_o,
  output logic               timer_int_o,
  output logic               int_req_o,
  output logic [31:0]        exc_pc_o
);

  localparam logic [4:0]  REG_COUNT   = 5'd9;
  localparam logic [4:0]  REG_COMPARE = 5'd11;
  localparam logic [4:0]  REG_STATUS  = 5'd12;
  localparam logic [4:0]  REG_CAUSE   = 5'd13;
  localparam logic [4:0]  REG_EPC     = 5'd14;
  localparam logic [4:0]  REG_PRID    = 5'd15;
  localparam logic [4:0]  REG_CONFIG  = 5'd16;

  localparam logic [31:0] STATUS_RST  = 32'h1000_0000;
  localparam logic [31:0] CONFIG_VAL  = 32'h0000_8000;
  // Only IP[1:0] (software interrupts) and bits 23:22 are software-writable.
  localparam logic [31:0] CAUSE_WMASK = 32'h00C0_0300;
  localparam logic [3:0]  PRESCALE_LAST = 4'(COUNT_DIV - 1);

  logic [31:0]        count_q, count_d;
  logic [3:0]         prescale_q, prescale_d;
  logic [31:0]        compare_q, compare_d;
  logic [31:0]        status_q, status_d;
  logic [31:0]        cause_q, cause_d;
  logic [31:0]        epc_q, epc_d;
  logic               timerInt_q, timerInt_d;
  logic               intReq_q, intReq_d;
  logic [INT_NUM-1:0] intMeta_q, intSync_q;
  logic [5:0]         ipBits;
  logic               excValid;
  logic               isEret;
  logic               isIntExc;
  logic [4:0]         excCode;
  logic               timerHit;
  logic [31:0]        readVal;

`ifdef CP0_BADVADDR_EN
  localparam logic [4:0] REG_BADVADDR = 5'd8;
  logic [31:0] badVaddr_q, badVaddr_d;
  logic        isAddrExc;
`else
  logic unusedBadVaddr;
  assign unusedBadVaddr = ^bad_vaddr_i;
`endif

  // The second synchroniser flop is the architectural Cause.IP field,
  // so the lines become visible in Cause two cycles after they change.
  assign ipBits   = 6'(intSync_q);
  assign timerHit = (compare_q != 32'd0) && (count_q == compare_q);

  // Decode the committed exception code into ExcCode / ERET / ignored.
  always_comb begin
    excValid = 1'b0;
    isEret   = 1'b0;
    isIntExc = 1'b0;
    excCode  = 5'd0;
`ifdef CP0_BADVADDR_EN
    isAddrExc = 1'b0;
`endif
    case (excepttype_i)
      32'h0000_0001: begin excValid = 1'b1; isIntExc = 1'b1; excCode = 5'd0; end
      32'h0000_0008: begin excValid = 1'b1; excCode = 5'd8;  end
      32'h0000_0009: begin excValid = 1'b1; excCode = 5'd9;  end
      32'h0000_000a: begin excValid = 1'b1; excCode = 5'd10; end
      32'h0000_000c: begin excValid = 1'b1; excCode = 5'd12; end
      32'h0000_000d: begin excValid = 1'b1; excCode = 5'd13; end
`ifdef CP0_BADVADDR_EN
      32'h0000_0004: begin excValid = 1'b1; isAddrExc = 1'b1; excCode = 5'd4; end
      32'h0000_0005: begin excValid = 1'b1; isAddrExc = 1'b1; excCode = 5'd5; end
`endif
      32'h0000_000e: isEret = 1'b1;
      default: ;
    endcase
  end

  // Next-state: timer/prescaler first, then software writes, then the
  // exception so that exception-owned fields win over a same-cycle write.
  always_comb begin
    count_d    = count_q;
    prescale_d = prescale_q;
    compare_d  = compare_q;
    status_d   = status_q;
    cause_d    = cause_q;
    epc_d      = epc_q;
    timerInt_d = timerInt_q | timerHit;
    intReq_d   = status_q[0] & ~status_q[1] &
                 ((|(ipBits & status_q[15:10])) | (timerInt_q & status_q[15]));

    if (prescale_q == PRESCALE_LAST) begin
      prescale_d = 4'd0;
      count_d    = count_q + 32'd1;
    end else begin
      prescale_d = prescale_q + 4'd1;
    end

    if (we_i) begin
      case (waddr_i)
        REG_COUNT: begin
          count_d    = data_i;
          prescale_d = 4'd0;
        end
        REG_COMPARE: begin
          compare_d  = data_i;
          timerInt_d = 1'b0;
        end
        REG_STATUS: status_d = data_i;
        REG_CAUSE:  cause_d  = (cause_q & ~CAUSE_WMASK) | (data_i & CAUSE_WMASK);
        REG_EPC:    epc_d    = data_i;
        default: ;
      endcase
    end

    if (excValid) begin
      // A nested exception keeps the original EPC, except Int which always reloads it.
      if (isIntExc || !status_q[1]) begin
        epc_d       = is_in_delayslot_i ? (current_inst_addr_i - 32'd4) : current_inst_addr_i;
        cause_d[31] = is_in_delayslot_i;
      end
      status_d[1]   = 1'b1;
      cause_d[6:2]  = excCode;
    end else if (isEret) begin
      status_d[1] = 1'b0;
    end
  end

  // Architectural state and synchroniser.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q    <= 32'd0;
      prescale_q <= 4'd0;
      compare_q  <= 32'd0;
      status_q   <= STATUS_RST;
      cause_q    <= 32'd0;
      epc_q      <= 32'd0;
      timerInt_q <= 1'b0;
      intReq_q   <= 1'b0;
      intMeta_q  <= '0;
      intSync_q  <= '0;
    end else begin
      count_q    <= count_d;
      prescale_q <= prescale_d;
      compare_q  <= compare_d;
      status_q   <= status_d;
      cause_q    <= cause_d;
      epc_q      <= epc_d;
      timerInt_q <= timerInt_d;
      intReq_q   <= intReq_d;
      intMeta_q  <= int_i;
      intSync_q  <= intMeta_q;
    end
  end

`ifdef CP0_BADVADDR_EN
  assign badVaddr_d = isAddrExc ? bad_vaddr_i : badVaddr_q;

  // BadVAddr is loaded by AdEL/AdES regardless of EXL.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      badVaddr_q <= 32'd0;
    end else begin
      badVaddr_q <= badVaddr_d;
    end
  end
`endif

  assign count_o     = count_q;
  assign compare_o   = compare_q;
  assign status_o    = status_q;
  assign cause_o     = cause_q | {1'b0, timerInt_q, 14'd0, ipBits, 10'd0};
  assign epc_o       = epc_q;
  assign config_o    = CONFIG_VAL;
  assign prid_o      = PRID_VAL;
  assign timer_int_o = timerInt_q;
  assign int_req_o   = intReq_q;

  // Read port: plain register mux, then a same-cycle write to the same
  // writable register is forwarded so the reader sees the post-write value.
  always_comb begin
    readVal = 32'd0;
    case (raddr_i)
`ifdef CP0_BADVADDR_EN
      REG_BADVADDR: readVal = badVaddr_q;
`endif
      REG_COUNT:   readVal = count_o;
      REG_COMPARE: readVal = compare_o;
      REG_STATUS:  readVal = status_o;
      REG_CAUSE:   readVal = cause_o;
      REG_EPC:     readVal = epc_o;
      REG_PRID:    readVal = prid_o;
      REG_CONFIG:  readVal = config_o;
      default: ;
    endcase
    if (we_i && (waddr_i == raddr_i)) begin
      case (waddr_i)
        REG_COUNT, REG_COMPARE, REG_STATUS, REG_EPC: readVal = data_i;
        REG_CAUSE: readVal = (cause_o & ~CAUSE_WMASK) | (data_i & CAUSE_WMASK);
        default: ;
      endcase
    end
    data_o = rst ? 32'd0 : readVal;
  end

  // Redirect PC: ERET returns to EPC, every recognised exception vectors.
  always_comb begin
    exc_pc_o = 32'd0;
    if (isEret) begin
      exc_pc_o = epc_q;
    end else if (excValid) begin
      exc_pc_o = EXC_VECTOR;
    end
  end

endmodule

// File: tb/tb_cp0_unit_p.sv
// ---------------------------------------------------------------------------
// tb_cp0_unit_p - self-checking bench for cp0_unit_p
//
// Two instances share all inputs:
//   dutA - INT_NUM=6, COUNT_DIV=2
//   dutB - INT_NUM=4, COUNT_DIV=1
//
// Count is modelled as anchor + elapsed/COUNT_DIV. Exceptions are modelled
// from the ExcCode table. Every cycle is compared against the model.
// ---------------------------------------------------------------------------
module tb_cp0_unit_p;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [4:0]  waddr, raddr;
  logic [31:0] dataIn, excType, pc, badVaddr;
  logic [5:0]  intIn;
  logic        ds;

  logic [31:0] dataA, countA, compareA, statusA, causeA, epcA, configA, pridA, excPcA;
  logic        timerA, intReqA;
  logic [31:0] dataB, countB, compareB, statusB, causeB, epcB, configB, pridB, excPcB;
  logic        timerB, intReqB;

  always #5 clk = ~clk;

  cp0_unit_p #(.INT_NUM(6), .COUNT_DIV(2)) dutA (
    .clk(clk), .rst(rst), .we_i(we), .waddr_i(waddr), .raddr_i(raddr),
    .data_i(dataIn), .excepttype_i(excType), .int_i(intIn),
    .current_inst_addr_i(pc), .is_in_delayslot_i(ds), .bad_vaddr_i(badVaddr),
    .data_o(dataA), .count_o(countA), .compare_o(compareA), .status_o(statusA),
    .cause_o(causeA), .epc_o(epcA), .config_o(configA), .prid_o(pridA),
    .timer_int_o(timerA), .int_req_o(intReqA), .exc_pc_o(excPcA)
  );

  cp0_unit_p #(.INT_NUM(4), .COUNT_DIV(1)) dutB (
    .clk(clk), .rst(rst), .we_i(we), .waddr_i(waddr), .raddr_i(raddr),
    .data_i(dataIn), .excepttype_i(excType), .int_i(intIn[3:0]),
    .current_inst_addr_i(pc), .is_in_delayslot_i(ds), .bad_vaddr_i(badVaddr),
    .data_o(dataB), .count_o(countB), .compare_o(compareB), .status_o(statusB),
    .cause_o(causeB), .epc_o(epcB), .config_o(configB), .prid_o(pridB),
    .timer_int_o(timerB), .int_req_o(intReqB), .exc_pc_o(excPcB)
  );

  localparam logic [31:0] CAUSE_MASK = 32'h00C0_0300;

  int tests = 0;
  int failures = 0;

  // Reference model state
  logic [31:0] mAnchor [2];
  int unsigned mElapsed [2];
  logic        mTimer [2];
  logic        mIntReq [2];
  logic [31:0] mCompare, mStatus, mEpc;
  logic        mBd;
  logic [4:0]  mExc;
  logic [1:0]  mIpSw, mHi;
  logic [5:0]  mIntNew, mIntOld;

  logic [31:0] obsDataA, obsExcA, obsExcB;
  logic        found;
  logic        rW, rDs;
  logic [4:0]  rWa, rRa;
  logic [31:0] rD, rEt, rPc;
  logic [5:0]  rInt;

  function automatic int divOf(input int i);
    return (i == 0) ? 2 : 1;
  endfunction

  function automatic logic [31:0] mCount(input int i);
    return mAnchor[i] + 32'(mElapsed[i] / divOf(i));
  endfunction

  function automatic logic [5:0] mIp(input int i);
    return mIntOld & ((i == 0) ? 6'h3F : 6'h0F);
  endfunction

  function automatic logic [31:0] mCause(input int i);
    return {mBd, mTimer[i], 6'd0, mHi, 6'd0, mIp(i), mIpSw, 1'b0, mExc, 2'b00};
  endfunction

  function automatic int excCodeOf(input logic [31:0] code);
    case (code)
      32'h01: return 0;
      32'h08: return 8;
      32'h09: return 9;
      32'h0a: return 10;
      32'h0c: return 12;
      32'h0d: return 13;
      default: return -1;
    endcase
  endfunction

  function automatic logic [31:0] mExcPc();
    if (excType == 32'h0e) return mEpc;
    if (excCodeOf(excType) >= 0) return 32'h0000_0020;
    return 32'd0;
  endfunction

  function automatic logic [31:0] mRead(input int i);
    if (rst) return 32'd0;
    if (we && waddr == raddr) begin
      if (waddr == 5'd9 || waddr == 5'd11 || waddr == 5'd12 || waddr == 5'd14) return dataIn;
      if (waddr == 5'd13) return (mCause(i) & ~CAUSE_MASK) | (dataIn & CAUSE_MASK);
    end
    case (raddr)
      5'd9:  return mCount(i);
      5'd11: return mCompare;
      5'd12: return mStatus;
      5'd13: return mCause(i);
      5'd14: return mEpc;
      5'd15: return 32'h004C_0102;
      5'd16: return 32'h0000_8000;
      default: return 32'd0;
    endcase
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 2; i++) begin
      mAnchor[i] = 32'd0;
      mElapsed[i] = 0;
      mTimer[i] = 1'b0;
      mIntReq[i] = 1'b0;
    end
    mCompare = 32'd0;
    mStatus = 32'h1000_0000;
    mEpc = 32'd0;
    mBd = 1'b0;
    mExc = 5'd0;
    mIpSw = 2'd0;
    mHi = 2'd0;
    mIntNew = 6'd0;
    mIntOld = 6'd0;
  endtask

  // One clock edge of architectural behaviour.
  task automatic modelStep();
    logic exlOld;
    logic nextTimer [2];
    logic nextReq [2];
    int code;
    exlOld = mStatus[1];
    for (int i = 0; i < 2; i++) begin
      nextTimer[i] = mTimer[i] | ((mCompare != 32'd0) && (mCount(i) == mCompare));
      nextReq[i] = mStatus[0] & ~mStatus[1] &
                   ((|(mIp(i) & mStatus[15:10])) | (mTimer[i] & mStatus[15]));
      mElapsed[i]++;
    end
    if (we) begin
      case (waddr)
        5'd9: for (int i = 0; i < 2; i++) begin mAnchor[i] = dataIn; mElapsed[i] = 0; end
        5'd11: begin mCompare = dataIn; nextTimer[0] = 1'b0; nextTimer[1] = 1'b0; end
        5'd12: mStatus = dataIn;
        5'd13: begin mHi = dataIn[23:22]; mIpSw = dataIn[9:8]; end
        5'd14: mEpc = dataIn;
        default: ;
      endcase
    end
    code = excCodeOf(excType);
    if (code >= 0) begin
      if (code == 0 || !exlOld) begin
        mEpc = ds ? pc - 32'd4 : pc;
        mBd = ds;
      end
      mStatus[1] = 1'b1;
      mExc = 5'(code);
    end else if (excType == 32'h0e) begin
      mStatus[1] = 1'b0;
    end
    mIntOld = mIntNew;
    mIntNew = intIn;
    for (int i = 0; i < 2; i++) begin
      mTimer[i] = nextTimer[i];
      mIntReq[i] = nextReq[i];
    end
  endtask

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    checkVal("countA", countA, mCount(0));
    checkVal("countB", countB, mCount(1));
    checkVal("compareA", compareA, mCompare);
    checkVal("compareB", compareB, mCompare);
    checkVal("statusA", statusA, mStatus);
    checkVal("statusB", statusB, mStatus);
    checkVal("causeA", causeA, mCause(0));
    checkVal("causeB", causeB, mCause(1));
    checkVal("epcA", epcA, mEpc);
    checkVal("epcB", epcB, mEpc);
    checkVal("configA", configA, 32'h0000_8000);
    checkVal("pridB", pridB, 32'h004C_0102);
    checkVal("timerA", {31'd0, timerA}, {31'd0, mTimer[0]});
    checkVal("timerB", {31'd0, timerB}, {31'd0, mTimer[1]});
    checkVal("intReqA", {31'd0, intReqA}, {31'd0, mIntReq[0]});
    checkVal("intReqB", {31'd0, intReqB}, {31'd0, mIntReq[1]});
  endtask

  // Drive one cycle: combinational checks mid-cycle, register checks after the edge.
  task automatic applyStimulus(input logic w, input logic [4:0] wa, input logic [31:0] d,
                               input logic [31:0] et, input logic [5:0] ii,
                               input logic [31:0] p, input logic dsl, input logic [4:0] ra);
    @(negedge clk);
    we = w; waddr = wa; dataIn = d; excType = et; intIn = ii;
    pc = p; ds = dsl; raddr = ra; badVaddr = p ^ 32'h5A5A_0000;
    #1;
    obsDataA = dataA;
    obsExcA = excPcA;
    obsExcB = excPcB;
    checkVal("dataA", dataA, mRead(0));
    checkVal("dataB", dataB, mRead(1));
    checkVal("excPcA", excPcA, mExcPc());
    checkVal("excPcB", excPcB, mExcPc());
    @(posedge clk);
    modelStep();
    #1;
    checkOutput();
  endtask

  task automatic idle(input logic [5:0] ii);
    applyStimulus(1'b0, 5'd0, 32'd0, 32'd0, ii, 32'd0, 1'b0, 5'd9);
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; waddr = 5'd0; raddr = 5'd15; dataIn = 32'd0;
    excType = 32'd0; intIn = 6'd0; pc = 32'd0; ds = 1'b0; badVaddr = 32'd0;
    modelReset();
    #1;
    checkVal("rst_count", countA, 32'd0);
    checkVal("rst_status", statusA, 32'h1000_0000);
    checkVal("rst_config", configB, 32'h0000_8000);
    checkVal("rst_prid", pridA, 32'h004C_0102);
    checkVal("rst_cause", causeB, 32'd0);
    checkVal("rst_data", dataA, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Prescaler: COUNT_DIV=2 reaches 1 after 2 cycles and 5 after 10
    for (int k = 1; k <= 10; k++) begin
      idle(6'd0);
      if (k == 2) checkVal("plan_countA_2", countA, 32'd1);
    end
    checkVal("plan_countA_10", countA, 32'd5);
    checkVal("plan_countB_10", countB, 32'd10);

    // Count wrap after writing all-ones
    applyStimulus(1'b1, 5'd9, 32'hFFFF_FFFF, 32'd0, 6'd0, 32'd0, 1'b0, 5'd9);
    idle(6'd0);
    idle(6'd0);
    checkVal("plan_wrapA", countA, 32'd0);

    // Timer: Compare=5, Count=3
    applyStimulus(1'b1, 5'd11, 32'd5, 32'd0, 6'd0, 32'd0, 1'b0, 5'd11);
    applyStimulus(1'b1, 5'd9, 32'd3, 32'd0, 6'd0, 32'd0, 1'b0, 5'd9);
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      idle(6'd0);
      if (countB == 32'd5) found = 1'b1;
    end
    checkVal("plan_countB_hit", countB, 32'd5);
    checkVal("plan_timerB_before", {31'd0, timerB}, 32'd0);
    idle(6'd0);
    checkVal("plan_timerB_rise", {31'd0, timerB}, 32'd1);
    idle(6'd0);
    idle(6'd0);
    checkVal("plan_timerB_hold", {31'd0, timerB}, 32'd1);
    applyStimulus(1'b1, 5'd11, 32'd0, 32'd0, 6'd0, 32'd0, 1'b0, 5'd11);
    checkVal("plan_timerB_clear", {31'd0, timerB}, 32'd0);

    // Interrupt path: 2 cycles to Cause.IP, 3 to int_req_o, masked by EXL
    applyStimulus(1'b1, 5'd12, 32'h0000_0401, 32'd0, 6'd0, 32'd0, 1'b0, 5'd12);
    idle(6'h01);
    checkVal("plan_ip_1", {31'd0, causeA[10]}, 32'd0);
    idle(6'h01);
    checkVal("plan_ipA_2", {31'd0, causeA[10]}, 32'd1);
    checkVal("plan_ipB_2", {31'd0, causeB[10]}, 32'd1);
    idle(6'h01);
    checkVal("plan_intReqA_3", {31'd0, intReqA}, 32'd1);
    checkVal("plan_intReqB_3", {31'd0, intReqB}, 32'd1);
    applyStimulus(1'b1, 5'd12, 32'h0000_0403, 32'd0, 6'h01, 32'd0, 1'b0, 5'd12);
    idle(6'h01);
    checkVal("plan_intReq_exl", {31'd0, intReqA}, 32'd0);
    idle(6'h00);
    applyStimulus(1'b1, 5'd12, 32'h1000_0000, 32'd0, 6'd0, 32'd0, 1'b0, 5'd12);

    // Syscall in delay slot, then ERET
    applyStimulus(1'b0, 5'd0, 32'd0, 32'h08, 6'd0, 32'h100, 1'b1, 5'd14);
    checkVal("plan_sys_vector", obsExcA, 32'h0000_0020);
    checkVal("plan_sys_epc", epcA, 32'h0000_00FC);
    checkVal("plan_sys_bd", {31'd0, causeA[31]}, 32'd1);
    checkVal("plan_sys_code", {27'd0, causeA[6:2]}, 32'd8);
    checkVal("plan_sys_exl", {31'd0, statusA[1]}, 32'd1);
    applyStimulus(1'b0, 5'd0, 32'd0, 32'h0e, 6'd0, 32'h0, 1'b0, 5'd14);
    checkVal("plan_eret_pc", obsExcB, 32'h0000_00FC);
    checkVal("plan_eret_exl", {31'd0, statusA[1]}, 32'd0);

    // Exception beats a same-cycle EPC write; bypass returns the write data
    applyStimulus(1'b1, 5'd14, 32'h40, 32'h0a, 6'd0, 32'h200, 1'b0, 5'd14);
    checkVal("plan_ri_epc", epcA, 32'h0000_0200);
    applyStimulus(1'b1, 5'd14, 32'h44, 32'd0, 6'd0, 32'h0, 1'b0, 5'd14);
    checkVal("plan_bypass_epc", obsDataA, 32'h0000_0044);

    // Int reloads EPC even with EXL set; 0x04 is ignored in this build
    applyStimulus(1'b0, 5'd0, 32'd0, 32'h01, 6'd0, 32'h300, 1'b0, 5'd13);
    checkVal("plan_int_epc", epcA, 32'h0000_0300);
    applyStimulus(1'b0, 5'd0, 32'd0, 32'h04, 6'd0, 32'h400, 1'b0, 5'd8);
    checkVal("plan_adel_pc", obsExcA, 32'd0);
    applyStimulus(1'b1, 5'd16, 32'hFFFF_FFFF, 32'd0, 6'd0, 32'h0, 1'b0, 5'd16);
    applyStimulus(1'b1, 5'd15, 32'hFFFF_FFFF, 32'd0, 6'd0, 32'h0, 1'b0, 5'd15);
    applyStimulus(1'b1, 5'd13, 32'hFFFF_FFFF, 32'd0, 6'd0, 32'h0, 1'b0, 5'd13);

    // Randomised traffic against the model
    for (int n = 0; n < 600; n++) begin
      rW = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 7))
        0: rWa = 5'd9;
        1: rWa = 5'd11;
        2: rWa = 5'd12;
        3: rWa = 5'd13;
        4: rWa = 5'd14;
        5: rWa = 5'd15;
        6: rWa = 5'd16;
        default: rWa = 5'($urandom);
      endcase
      rD = $urandom;
      if (rWa == 5'd11 && $urandom_range(0, 1) == 1) rD = mCount(1) + 32'($urandom_range(1, 4));
      if (rWa == 5'd12 && $urandom_range(0, 1) == 1) rD = rD & 32'h0000_FC01;
      rEt = 32'd0;
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 9))
          0: rEt = 32'h01;
          1: rEt = 32'h04;
          2: rEt = 32'h05;
          3: rEt = 32'h08;
          4: rEt = 32'h09;
          5: rEt = 32'h0a;
          6: rEt = 32'h0c;
          7: rEt = 32'h0d;
          8: rEt = 32'h0e;
          default: rEt = $urandom;
        endcase
      end
      rInt = intIn;
      if ($urandom_range(0, 4) == 0) rInt = 6'($urandom);
      rPc = $urandom & 32'hFFFF_FFFC;
      rDs = 1'($urandom);
      rRa = ($urandom_range(0, 1) == 1) ? rWa : 5'($urandom_range(8, 17));
      applyStimulus(rW, rWa, rD, rEt, rInt, rPc, rDs, rRa);
    end

    // Asynchronous reset in the middle of counting with the timer set
    applyStimulus(1'b1, 5'd11, 32'd7, 32'd0, 6'd0, 32'd0, 1'b0, 5'd9);
    applyStimulus(1'b1, 5'd9, 32'd6, 32'd0, 6'd0, 32'd0, 1'b0, 5'd9);
    idle(6'd0);
    idle(6'd0);
    checkVal("plan_timerB_pre_rst", {31'd0, timerB}, 32'd1);
    @(negedge clk);
    #2;
    rst = 1'b1;
    raddr = 5'd15;
    #1;
    checkVal("arst_count", countA, 32'd0);
    checkVal("arst_compare", compareB, 32'd0);
    checkVal("arst_timer", {31'd0, timerB}, 32'd0);
    checkVal("arst_status", statusB, 32'h1000_0000);
    checkVal("arst_cause", causeB, 32'd0);
    checkVal("arst_epc", epcA, 32'd0);
    checkVal("arst_config", configA, 32'h0000_8000);
    checkVal("arst_prid", pridB, 32'h004C_0102);
    checkVal("arst_intReq", {31'd0, intReqA}, 32'd0);
    checkVal("arst_data", dataA, 32'd0);
    modelReset();
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 4; k++) idle(6'd0);
    checkVal("post_rst_countB", countB, 32'd4);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule

// File: doc/cp0_unit_p.md
Name: cp0_unit_p

Overview:
Parametrised second-generation coprocessor-0 block for the MIPS core; sits beside the MEM/WB boundary and owns Count/Compare/Status/Cause/EPC/PrId/Config.
Adds configurable hardware-interrupt count, a Count prescaler, a 2-flop interrupt synchroniser, a masked interrupt-request output, read-after-write bypass and an exception vector output.
The exception/ctrl stage consumes int_req_o and exc_pc_o to redirect fetch.

Parameters:
INT_NUM, 6, number of external interrupt lines (1..6), mapped to Cause.IP[10+:INT_NUM].
COUNT_DIV, 1, Count increments once every COUNT_DIV cycles (1..16).
PRID_VAL, 32'h004C0102, PrId reset/constant value.
EXC_VECTOR, 32'h00000020, target PC for all exceptions except ERET.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
we_i  in  1  CP0 write enable
waddr_i  in  5  write register number
raddr_i  in  5  read register number
data_i  in  32  write data
excepttype_i  in  32  committed exception code (0 = none)
int_i  in  INT_NUM  asynchronous external interrupts
current_inst_addr_i  in  32  PC of excepting instruction
is_in_delayslot_i  in  1  excepting instruction is in a delay slot
bad_vaddr_i  in  32  faulting address (used only with CP0_BADVADDR_EN)
data_o  out  32  read data (combinational)
count_o, compare_o, status_o, cause_o, epc_o, config_o, prid_o  out  32 each  register values
timer_int_o  out  1  sticky timer interrupt
int_req_o  out  1  interrupt request to ctrl
exc_pc_o  out  32  redirect PC for the exception in excepttype_i (combinational)

Behaviour:
- Reset (async, any time, incl. mid-operation): count=0, compare=0, status=32'h1000_0000, cause=0, epc=0, config=32'h0000_8000, prid=PRID_VAL, timer_int_o=0, synchroniser flops=0, prescaler=0.
- Prescaler: counts 0..COUNT_DIV-1; Count+1 on terminal value; Count wraps 32'hFFFF_FFFF->0.
- Count write (reg 9) overrides the increment in the same cycle and clears the prescaler.
- Timer: when compare!=0 and count==compare, timer_int_o<=1 next cycle and stays set; write to Compare (reg 11) loads compare and clears timer_int_o (the clear wins over a same-cycle match).
- int_i passes through 2 flops; Cause[10+:INT_NUM] <= sync every cycle; Cause bits [15:10+INT_NUM] read 0. Cause[30] (TI) mirrors timer_int_o. Latency int_i -> Cause.IP = 2 cycles; -> int_req_o = 3 cycles.
- int_req_o = Status.IE(0) & ~Status.EXL(1) & |(Cause.IP[15:10] & Status.IM[15:8→ bits 15:10]) | (timer_int_o & Status.IM[15]).
- Writable: Status (all bits), EPC, Cause[9:8], Cause[23:22], Compare, Count. Writes to Config/PrId ignored.
- Exceptions (excepttype_i): 0x01 Int ExcCode 0, 0x08 Sys 8, 0x09 Bp 9, 0x0a RI 10, 0x0c Ov 12, 0x0d Tr 13. On each: if EXL==0 (Int: unconditionally), EPC<=PC (or PC-4 in delay slot) and Cause.BD set accordingly; EXL<=1; Cause[6:2]<=ExcCode. 0x0e ERET: EXL<=0. Other codes: no effect.
- Same-cycle we_i and exception: exception-updated fields take the exception value; other written fields take data_i.
- exc_pc_o = epc_o for 0x0e, EXC_VECTOR for recognised codes, 0 otherwise.
- Read: data_o per raddr_i (9 Count, 11 Compare, 12 Status, 13 Cause, 14 EPC, 15 PrId, 16 Config), else 0; rst high -> 0. Bypass: if we_i and waddr_i==raddr_i for a writable register, data_o returns the post-write value (Cause merged by field mask).

Optional Feature:
CP0_BADVADDR_EN: adds BadVAddr (reg 8, read-only, reset 0) and codes 0x04 AdEL (ExcCode 4), 0x05 AdES (ExcCode 5), both loading BadVAddr<=bad_vaddr_i plus the standard EPC/EXL handling. Without it: reg 8 reads 0, codes 0x04/0x05 are ignored and exc_pc_o is 0 for them.

Test Plan:
COUNT_DIV=2, release reset -> count_o=1 after 2 cycles, 5 after 10; write Count=32'hFFFF_FFFF -> wraps to 0 after 2 more cycles.
Compare=5, Count=3 with COUNT_DIV=1 -> timer_int_o rises when count_o=5, holds; write Compare=0 -> timer_int_o=0 next cycle.
Status=32'h0000_0401, pulse int_i[0] -> Cause[10]=1 after 2 cycles, int_req_o=1 after 3; set EXL -> int_req_o=0.
excepttype 0x08, PC=0x100, delay slot=1 -> EPC=0xFC, Cause[31]=1, Cause[6:2]=8, EXL=1, exc_pc_o=0x20; then 0x0e -> EXL=0, exc_pc_o=0xFC.
Same-cycle write EPC=0x40 and exception 0x0a with EXL=0 at PC=0x200 -> EPC=0x200; we_i EPC=0x44 with raddr=14 -> data_o=0x44 same cycle.
Assert rst mid-count with timer_int_o=1 -> all outputs at reset values immediately (before next clk edge).
